// File: rtl/matrix_pkg.sv
// Shared types and RAM geometry for the matrix multiplier slice:
// arbiter state encoding, RAM owner encoding and default RAM widths.
package matrix_pkg;

  localparam int MAT_DATA_W = 32;
  localparam int MAT_RAM_D  = 512;
  localparam int MAT_ADDR_W = $clog2(MAT_RAM_D);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_RUN
  } arb_state_t;

  typedef enum logic {
    OWN_HOST,
    OWN_CU
  } owner_t;

endpackage

// File: rtl/matrix_arb_timer.sv
// Loadable down-counter with a zero flag. Load wins over count; the
// counter parks at zero so the flag stays asserted until the next load.
module matrix_arb_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Count register: load, else decrement toward zero while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/matrix_ram_arbiter.sv
// Arbiter sharing the single-port matrix RAM between the host port and
// the 2x2 block multiplier control unit (CU).
// Optional watchdog on the CU run: define MATRIX_RAM_ARB_WDT_EN.
// Host accesses are registered onto the RAM pins (one cycle to reach the
// RAM, then RD_LAT for read data); the CU drives the pins directly in RUN.
module matrix_ram_arbiter
  import matrix_pkg::*;
#(
  parameter int DATA_W  = MAT_DATA_W,
  parameter int RAM_D   = MAT_RAM_D,
  parameter int ADDR_W  = $clog2(RAM_D),
  parameter int RD_LAT  = 1,
  parameter int WDT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              mul_start,
  output logic              busy,
  output logic              mul_done,
  output logic              mul_err,
  output logic              cu_start,
  output logic              cu_abort,
  input  logic              cu_done,
  input  logic              cu_err,
  input  logic [ADDR_W-1:0] cu_ram_addr,
  input  logic              cu_ram_we,
  input  logic [DATA_W-1:0] cu_ram_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data
);

  // Timer must hold both the SWITCH hold count (<= 4) and the watchdog limit.
  localparam int TMR_W    = ($clog2(WDT_CYC + 1) > 3) ? $clog2(WDT_CYC + 1) : 3;
  localparam int HOLD_CYC = RD_LAT + 1;

`ifdef MATRIX_RAM_ARB_WDT_EN
  // Loaded on cu_start so the timer reaches zero in RUN cycle WDT_CYC.
  localparam logic [TMR_W-1:0] WDT_LOAD = TMR_W'(WDT_CYC - 1);
`else
  localparam logic [TMR_W-1:0] WDT_LOAD = '0;
`endif

  arb_state_t        state_reg, state_next;
  owner_t            owner;
  logic [RD_LAT:0]   rv_pipe_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic              ram_we_reg;
  logic [DATA_W-1:0] ram_w_data_reg;
  logic              cu_done_q_reg, cu_err_q_reg;
  logic              done_rise, err_rise;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;
  logic              enter_switch, leave_run, wdt_expire;

  assign done_rise  = cu_done & ~cu_done_q_reg;
  assign err_rise   = cu_err & ~cu_err_q_reg;
  assign host_rdata = ram_r_data;
  assign host_rvalid = rv_pipe_reg[RD_LAT];

`ifdef MATRIX_RAM_ARB_WDT_EN
  assign wdt_expire = tmr_zero;
`else
  assign wdt_expire = 1'b0;
`endif

  // Shared hold / watchdog counter.
  matrix_arb_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state, ownership, grants and run status pulses.
  always_comb begin
    state_next   = state_reg;
    owner        = OWN_HOST;
    host_gnt     = 1'b0;
    busy         = (state_reg != ST_IDLE);
    mul_done     = 1'b0;
    mul_err      = 1'b0;
    cu_start     = 1'b0;
    cu_abort     = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_en       = 1'b0;
    enter_switch = 1'b0;
    leave_run    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A start request beats a simultaneous host request.
        if (mul_start) begin
          busy       = 1'b1;
          state_next = ST_DRAIN;
        end else begin
          host_gnt = host_req;
        end
      end
      ST_DRAIN: begin
        // Wait until every granted host read has delivered its rvalid.
        if (rv_pipe_reg == '0) begin
          state_next   = ST_SWITCH;
          enter_switch = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = TMR_W'(HOLD_CYC);
        end
      end
      ST_SWITCH: begin
        // CU address is on the pins; give its first read time to arrive.
        owner = OWN_CU;
        if (tmr_zero) begin
          cu_start   = 1'b1;
          state_next = ST_RUN;
          tmr_load   = 1'b1;
          tmr_val    = WDT_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RUN: begin
        owner  = OWN_CU;
        tmr_en = 1'b1;
        if (err_rise) begin
          mul_err   = 1'b1;
          leave_run = 1'b1;
        end else if (done_rise) begin
          mul_done  = 1'b1;
          leave_run = 1'b1;
        end else if (wdt_expire) begin
          cu_abort  = 1'b1;
          mul_err   = 1'b1;
          leave_run = 1'b1;
        end
        if (leave_run) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // RAM pin mux; write is suppressed on the cycle ownership returns to host.
  always_comb begin
    if (owner == OWN_CU) begin
      ram_addr   = cu_ram_addr;
      ram_w_data = cu_ram_wdata;
      ram_we     = (state_reg == ST_RUN) && !leave_run && cu_ram_we;
    end else begin
      ram_addr   = ram_addr_reg;
      ram_w_data = ram_w_data_reg;
      ram_we     = ram_we_reg;
    end
  end

  // Host access registers and read-valid pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr_reg   <= '0;
      ram_we_reg     <= 1'b0;
      ram_w_data_reg <= '0;
      rv_pipe_reg    <= '0;
    end else begin
      if (host_gnt) begin
        ram_addr_reg   <= host_addr;
        ram_w_data_reg <= host_wdata;
      end
      ram_we_reg  <= host_gnt & host_we;
      rv_pipe_reg <= {rv_pipe_reg[RD_LAT-1:0], host_gnt & ~host_we};
    end
  end

  // Delayed CU status for edge detection; cleared as the CU takes the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cu_done_q_reg <= 1'b0;
      cu_err_q_reg  <= 1'b0;
    end else if (enter_switch) begin
      cu_done_q_reg <= 1'b0;
      cu_err_q_reg  <= 1'b0;
    end else begin
      cu_done_q_reg <= cu_done;
      cu_err_q_reg  <= cu_err;
    end
  end

endmodule
